// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: controller strobes, boot-loader byte stream, and status/IR fields returned to the controller.
interface fetch_unit_if #(parameter int ADDR_W = 8);
    logic              loadIR;
    logic              incPC;
    logic              loadPC;
    logic              selPC;
    logic              halt;
    logic [7:0]        regOut;
    logic              ldValid;
    logic [7:0]        ldData;
    logic              ldLast;
    logic              ldReady;
    logic              cpuRun;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        opcode;
    logic [3:0]        operand;

    modport master (
        output loadIR, incPC, loadPC, selPC, halt, regOut, ldValid, ldData, ldLast,
        input  ldReady, cpuRun, pc, opcode, operand
    );

    modport slave (
        input  loadIR, incPC, loadPC, selPC, halt, regOut, ldValid, ldData, ldLast,
        output ldReady, cpuRun, pc, opcode, operand
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: boot-loaded program memory, PC and IR driven by the controller strobes.
// Optional breakpoint-on-fetch logic is built when FETCH_BKPT_EN is defined.
//
//   state  | meaning
//   BOOT   | accepting boot bytes into memory from address 0; controls ignored
//   RUN    | controller drives loadIR/incPC/loadPC; cpuRun=1
//   HALTED | pc and IR frozen until rst
module fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int IMM_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FETCH_BKPT_EN
    input  logic [ADDR_W-1:0] bkptAddr,
    input  logic              bkptArm,
    output logic              bkptHit,
`endif
    fetch_unit_if.slave       bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] BOOT   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ld_addr;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] reg_target;
    logic [7:0]        ir;
    logic [7:0]        mem [DEPTH];
    logic              ld_fire;
    logic              ld_done;
    logic              bkpt_stop;

    assign ld_fire = (state == BOOT) && bus.ldValid;
    assign ld_done = ld_fire && (bus.ldLast || (ld_addr == '1));

    if (ADDR_W <= 8) begin : g_reg_trunc
        assign reg_target = bus.regOut[ADDR_W-1:0];
    end else begin : g_reg_ext
        assign reg_target = {{(ADDR_W-8){1'b0}}, bus.regOut};
    end

    // Immediate target uses the IR held before this edge, not one being loaded now.
    assign target = bus.selPC ? {{(ADDR_W-IMM_W){1'b0}}, ir[IMM_W-1:0]} : reg_target;

`ifdef FETCH_BKPT_EN
    assign bkpt_stop = (state == RUN) && bus.loadIR && bkptArm && (pc == bkptAddr);

    always_ff @(posedge clk) begin
        if (rst) begin
            bkptHit <= 1'b0;
        end else if (bkpt_stop) begin
            bkptHit <= 1'b1;
        end
    end
`else
    assign bkpt_stop = 1'b0;
`endif

    // Program memory is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && ld_fire) begin
            mem[ld_addr] <= bus.ldData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BOOT;
            pc      <= '0;
            ir      <= 8'h00;
            ld_addr <= '0;
        end else begin
            case (state)
                BOOT: begin
                    if (ld_fire) begin
                        ld_addr <= ld_addr + ADDR_W'(1);
                        if (ld_done) begin
                            state <= RUN;
                            pc    <= '0;
                        end
                    end
                end
                RUN: begin
                    if (bus.loadIR) begin
                        ir <= mem[pc];
                    end
                    if (bus.loadPC) begin
                        pc <= target;
                    end else if (bus.incPC) begin
                        pc <= pc + ADDR_W'(1);
                    end
                    if (bus.halt || bkpt_stop) begin
                        state <= HALTED;
                    end
                end
                HALTED: begin
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    assign bus.ldReady = (state == BOOT);
    assign bus.cpuRun  = (state == RUN);
    assign bus.pc      = pc;
    assign bus.opcode  = ir[7:4];
    assign bus.operand = ir[3:0];
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed boot/run/halt scenarios followed by randomized
// traffic, all compared against a cycle-level behavioural model of the fetch unit.
module tb_fetch_unit;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    logic [ADDR_W-1:0] bkpt_addr;
    logic              bkpt_arm;
`ifdef FETCH_BKPT_EN
    logic              bkpt_hit;

    fetch_unit #(.ADDR_W(ADDR_W), .IMM_W(4)) dut (
        .clk(clk), .rst(rst),
        .bkptAddr(bkpt_addr), .bkptArm(bkpt_arm), .bkptHit(bkpt_hit),
        .bus(bus)
    );
`else
    fetch_unit #(.ADDR_W(ADDR_W), .IMM_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int         m_state;
    int         m_pc;
    int         m_ld;
    logic [7:0] m_ir;
    logic [7:0] m_mem [DEPTH];
    bit         m_hit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [7:0] old_ir;
        bit         stop;
        if (rst) begin
            m_state = M_BOOT; m_pc = 0; m_ir = 8'h00; m_ld = 0; m_hit = 0;
            return;
        end
        case (m_state)
            M_BOOT: begin
                if (bus.ldValid) begin
                    m_mem[m_ld] = bus.ldData;
                    if (bus.ldLast || m_ld == DEPTH - 1) begin
                        m_state = M_RUN;
                        m_pc    = 0;
                    end
                    m_ld = (m_ld + 1) % DEPTH;
                end
            end
            M_RUN: begin
                old_ir = m_ir;
                stop   = bus.halt;
`ifdef FETCH_BKPT_EN
                if (bus.loadIR && bkpt_arm && m_pc == int'(bkpt_addr)) begin
                    stop  = 1;
                    m_hit = 1;
                end
`endif
                if (bus.loadIR) m_ir = m_mem[m_pc];
                if (bus.loadPC)
                    m_pc = bus.selPC ? int'(old_ir) % 16 : int'(bus.regOut) % DEPTH;
                else if (bus.incPC)
                    m_pc = (m_pc + 1) % DEPTH;
                if (stop) m_state = M_HALT;
            end
            default: ;
        endcase
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk({tag, "_pc"},      bus.pc,      m_pc);
        chk({tag, "_opcode"},  bus.opcode,  m_ir[7:4]);
        chk({tag, "_operand"}, bus.operand, m_ir[3:0]);
        chk({tag, "_ldReady"}, bus.ldReady, (m_state == M_BOOT));
        chk({tag, "_cpuRun"},  bus.cpuRun,  (m_state == M_RUN));
`ifdef FETCH_BKPT_EN
        chk({tag, "_bkptHit"}, bkpt_hit,    m_hit);
`endif
    endtask

    task automatic set_idle();
        bus.loadIR = 0; bus.incPC = 0; bus.loadPC = 0; bus.selPC = 0; bus.halt = 0;
        bus.regOut = 8'h00; bus.ldValid = 0; bus.ldData = 8'h00; bus.ldLast = 0;
        bkpt_addr = '0; bkpt_arm = 0;
    endtask

    task automatic load_byte(input logic [7:0] data, input logic last);
        bus.ldValid = 1; bus.ldData = data; bus.ldLast = last;
        tick("load");
        bus.ldValid = 0; bus.ldLast = 0;
    endtask

    task automatic ctl(input logic li, input logic ip, input logic lp, input logic sp,
                       input logic [7:0] ro, input string tag);
        bus.loadIR = li; bus.incPC = ip; bus.loadPC = lp; bus.selPC = sp; bus.regOut = ro;
        tick(tag);
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1;
        tick("reset");
        tick("reset");
        chk("rst_ldReady", bus.ldReady, 1);
        chk("rst_cpuRun",  bus.cpuRun,  0);
        chk("rst_pc",      bus.pc,      0);
        chk("rst_ir",      {bus.opcode, bus.operand}, 8'h00);
        rst = 0;

        // Boot with controller noise that BOOT must ignore
        bus.loadIR = 1; bus.incPC = 1; bus.loadPC = 1; bus.halt = 1; bus.regOut = 8'h77;
        load_byte(8'hD5, 0);
        load_byte(8'h1A, 0);
        chk("boot_pc_ignored", bus.pc, 0);
        chk("boot_ldReady",    bus.ldReady, 1);
        load_byte(8'hF0, 1);
        set_idle();
        chk("t1_ldReady", bus.ldReady, 0);
        chk("t1_cpuRun",  bus.cpuRun,  1);
        chk("t1_pc",      bus.pc,      0);

        ctl(1, 1, 0, 0, 8'h00, "t2");
        chk("t2_opcode",  bus.opcode,  4'hD);
        chk("t2_operand", bus.operand, 4'h5);
        chk("t2_pc",      bus.pc,      1);
        ctl(1, 1, 0, 0, 8'h00, "fetch1");
        chk("mem1", {bus.opcode, bus.operand}, 8'h1A);
        ctl(1, 0, 0, 0, 8'h00, "fetch2");
        chk("mem2", {bus.opcode, bus.operand}, 8'hF0);

        ctl(0, 1, 1, 0, 8'h3C, "t3_reg");
        chk("t3_reg_pc", bus.pc, 8'h3C);
        ctl(0, 0, 1, 0, 8'hFF, "t4_set");
        ctl(0, 1, 0, 0, 8'h00, "t4_wrap");
        chk("t4_wrap_pc", bus.pc, 8'h00);

        // Full-depth load without ldLast
        rst = 1; tick("rst2"); rst = 0;
        for (int i = 0; i < DEPTH; i++) begin
            load_byte((i == 0) ? 8'h29 : 8'($urandom), 0);
            if (i == DEPTH - 2) chk("full_still_boot", bus.ldReady, 1);
        end
        chk("full_cpuRun",  bus.cpuRun,  1);
        chk("full_ldReady", bus.ldReady, 0);

        ctl(1, 0, 0, 0, 8'h00, "t3b_fetch");
        ctl(0, 1, 1, 1, 8'hAB, "t3_imm");
        chk("t3_imm_pc", bus.pc, 8'h09);

        // Halt with same-cycle fetch and increment
        bus.halt = 1;
        ctl(1, 1, 0, 0, 8'h00, "t5_halt");
        chk("t5_cpuRun", bus.cpuRun, 0);
        chk("t5_pc",     bus.pc,     8'h0A);
        chk("t5_ir",     {bus.opcode, bus.operand}, m_mem[9]);
        for (int i = 0; i < 5; i++) begin
            bus.ldValid = 1; bus.ldData = 8'($urandom);
            ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), "t5_frozen");
        end
        chk("t5_frozen_pc", bus.pc, 8'h0A);
        rst = 1; tick("t5_rst"); rst = 0;
        chk("t5_rst_ldReady", bus.ldReady, 1);
        chk("t5_rst_pc",      bus.pc,      0);
        chk("t5_rst_ir",      {bus.opcode, bus.operand}, 8'h00);

        // Reset mid-load keeps already written bytes; new load restarts at 0
        load_byte(8'h11, 0);
        load_byte(8'h22, 0);
        rst = 1; tick("midload_rst"); rst = 0;
        load_byte(8'h33, 1);
        ctl(1, 1, 0, 0, 8'h00, "reload0");
        chk("reload0_ir", {bus.opcode, bus.operand}, 8'h33);
        ctl(1, 0, 0, 0, 8'h00, "kept1");
        chk("kept1_ir", {bus.opcode, bus.operand}, 8'h22);

`ifdef FETCH_BKPT_EN
        ctl(0, 0, 1, 0, 8'h02, "bk_goto");
        bkpt_addr = 8'h02; bkpt_arm = 1;
        ctl(1, 1, 0, 0, 8'h00, "bk_armed");
        chk("bk_hit",    bkpt_hit,   1);
        chk("bk_halted", bus.cpuRun, 0);
        chk("bk_ir",     {bus.opcode, bus.operand}, m_mem[2]);
        rst = 1; tick("bk_rst"); rst = 0;
        chk("bk_rst_hit", bkpt_hit, 0);
        load_byte(8'h33, 1);
        ctl(0, 0, 1, 0, 8'h02, "bk_goto2");
        bkpt_addr = 8'h02; bkpt_arm = 0;
        ctl(1, 0, 0, 0, 8'h00, "bk_disarmed");
        chk("bk_nohit", bkpt_hit,   0);
        chk("bk_run",   bus.cpuRun, 1);
`endif

        // Randomized traffic across all states
        for (int i = 0; i < 2000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            bus.loadIR  = 1'($urandom);
            bus.incPC   = 1'($urandom);
            bus.loadPC  = ($urandom_range(0, 3) == 0);
            bus.selPC   = 1'($urandom);
            bus.halt    = ($urandom_range(0, 59) == 0);
            bus.regOut  = 8'($urandom);
            bus.ldValid = 1'($urandom);
            bus.ldData  = 8'($urandom);
            bus.ldLast  = ($urandom_range(0, 3) == 0);
            bkpt_addr   = 8'($urandom);
            bkpt_arm    = ($urandom_range(0, 7) == 0);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
